ic_stage: RTL and testbench
===========================

Name: ic_stage

Overview:
- Instruction-cache stage directly downstream of the ITLB stage.
- Consumes the registered IT-to-IC bus plus the physical tag and uncached flag, and performs a 2-way set-associative tag compare.
- On a miss or uncached fetch, runs a refill FSM against the memory read port and raises a stall request.
- Registers the fetched instruction into the IC-to-ID bus.

Parameters:
- SETS, 128, number of sets; index = pc[11:5].
- LINE_WORDS, 8, 32-bit words per line; offset = pc[4:2].
- WAYS, fixed at 2; not overridable.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- stall  in  StallBus  pipeline stall vector; this stage uses stall[2] and stall[3]
- flush  in  1  exception flush
- br_e  in  1  branch redirect
- it_to_ic_bus  in  IT_TO_IC_WD  [31:0] pc, [32] fetch enable, [33] pc-misaligned flag, [34] tlb refill, [35] tlb invalid, [64:36] passthrough
- inst_uncached  in  1  fetch bypasses cache
- inst_tag  in  20  physical tag for pc
- stallreq_ic  out  1  stage needs more cycles
- rd_req  out  1  memory read request
- rd_type  out  1  0 = single word, 1 = full line
- rd_addr  out  32  request address
- rd_rdy  in  1  request accepted
- ret_valid  in  1  return beat valid
- ret_last  in  1  final beat
- ret_data  in  32  return beat data
- ic_to_id_bus  out  IC_TO_ID_WD  {it_to_ic_bus[64:32], inst[31:0], pc[31:0]}

Behaviour:
- Reset values:
  - All tag-valid bits and LRU bits 0.
  - FSM in IDLE; rd_req 0; stallreq_ic 0; ic_to_id_bus all 0.
- Request definition: req = it_to_ic_bus[32]. Bits 34/35 already gate it upstream, so no fetch ever issues for a TLB exception.
- Lookup (combinational, IDLE only):
  - hit_w = valid[w][idx] & (tag[w][idx] == inst_tag).
  - hit = req & ~inst_uncached & (hit_w0 | hit_w1).
  - Selected word = data[hit way][idx][offset].
- Latency:
  - Hit: 1 cycle; no stall.
  - Line miss: stall from detect cycle until DONE.
- FSM states:
  - IDLE:
    - req & uncached → MISS, rd_type = 0, rd_addr = {inst_tag, pc[11:0]}.
    - req & ~hit & cached → MISS, rd_type = 1, rd_addr = {inst_tag, pc[11:5], 5'b0}.
    - stallreq_ic = 1 in the detect cycle.
  - MISS: rd_req = 1, address and type held stable. On rd_rdy → REFILL.
  - REFILL: each ret_valid writes ret_data into the line buffer at beat counter cnt (3-bit, wraps after 7).
    - Beat with cnt == offset is captured as the fetched instruction.
    - On ret_last: a cached fill writes tag, valid = 1 and data into the victim way, then → DONE.
    - Victim way = first invalid way, else ~LRU[idx].
    - An uncached fetch writes nothing.
  - DONE: stallreq_ic = 0 for one cycle; the captured word is used as inst → IDLE.
- LRU update: on a hit, LRU[idx] = hit way; on a fill, LRU[idx] = filled way.
- Stall request: stallreq_ic = 1 whenever (IDLE & req & (miss | uncached)), MISS, or REFILL.
- Output register:
  - rst, flush or br_e → ic_to_id_bus = 0.
  - Else if stall[2]==Stop & stall[3]==NoStop → 0 (bubble).
  - Else if stall[2]==NoStop → load new value.
  - Else hold.
- Flush or br_e during MISS/REFILL:
  - The burst cannot be aborted; FSM continues to ret_last and still fills the cache line.
  - A cancel flag is set; in DONE the captured word is discarded and the output stays 0.
  - The cancel flag clears on IDLE entry.
- Simultaneous flush and hit in IDLE: flush wins; no LRU update.
- ret_valid outside REFILL is ignored.
- rst mid-refill: FSM → IDLE and all valid bits cleared; the memory side is reset by the same rst.

Decomposition:
- Shared defines header gets:
  - IC_TO_ID_WD.
  - Bus field offsets for it_to_ic_bus.
  - RD_TYPE_WORD/RD_TYPE_LINE.
  - FSM state encodings (IDLE, MISS, REFILL, DONE).
- One sub-module, ic_way_array: per-way tag/valid/data storage with a combinational read port and a synchronous line-write port; instantiated twice.

Test Plan:
- Cold fetch pc 0x1000_0040, tag 0x1000_0, cached:
  - rd_type = 1 and rd_addr = 0x1000_0040.
  - 8 beats 0xA0..0xA7 returned; inst = 0xA0.
  - Refetch of pc 0x1000_0044 hits in 1 cycle with inst = 0xA1 and no stall.
- Uncached fetch pc 0x1FC0_0000:
  - rd_type = 0; single beat 0x3C08_BFC0 returned; inst = 0x3C08_BFC0.
  - Same pc fetched again misses again (no fill).
- Three distinct tags mapping to index 2:
  - Third fill evicts the least-recently used way.
  - Refetch of the evicted tag misses; the other two hit.
- br_e asserted during REFILL beat 3:
  - Burst completes and the line becomes valid.
  - ic_to_id_bus stays 0; next fetch of the same line hits.
- stall[2] = Stop with stall[3] = NoStop during a hit: bubble (all-zero) output; when stall[2] releases, the held fetch is delivered.
- it_to_ic_bus[34] = 1 (tlb refill) with fetch enable 0: no rd_req, no stall; exception bits are passed through to ic_to_id_bus.

Source files
------------

// File: rtl/ic_stage_pkg.sv
// Shared widths, bus field offsets and FSM encoding for the instruction-cache stage.
package ic_stage_pkg;

    localparam int unsigned IT_TO_IC_WD = 65;
    localparam int unsigned IC_TO_ID_WD = 97;
    localparam int unsigned STALL_WD    = 6;
    localparam int unsigned TAG_WD      = 20;

    // it_to_ic_bus field offsets
    localparam int unsigned IT_PC_MSB         = 31;
    localparam int unsigned IT_FE_BIT         = 32;
    localparam int unsigned IT_TLB_REFILL_BIT = 34;

    localparam logic RD_TYPE_WORD = 1'b0;
    localparam logic RD_TYPE_LINE = 1'b1;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    typedef logic [STALL_WD-1:0] stall_bus_t;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StMiss   = 2'd1,
        StRefill = 2'd2,
        StDone   = 2'd3
    } ic_state_e;

endpackage

// File: rtl/ic_stage_if.sv
// Memory read port between the instruction cache and the memory side.
interface ic_stage_if;
    logic        rd_req;
    logic        rd_type;
    logic [31:0] rd_addr;
    logic        rd_rdy;
    logic        ret_valid;
    logic        ret_last;
    logic [31:0] ret_data;

    modport master (
        output rd_req, rd_type, rd_addr,
        input  rd_rdy, ret_valid, ret_last, ret_data
    );

    modport slave (
        input  rd_req, rd_type, rd_addr,
        output rd_rdy, ret_valid, ret_last, ret_data
    );
endinterface

// File: rtl/ic_way_array.sv
// One cache way: tag/valid/data storage, combinational read, whole-line synchronous write.
module ic_way_array
    import ic_stage_pkg::*;
#(
    parameter int unsigned SETS       = 128,
    parameter int unsigned LINE_WORDS = 8,
    localparam int unsigned IDX_W     = $clog2(SETS),
    localparam int unsigned OFF_W     = $clog2(LINE_WORDS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [IDX_W-1:0]            rd_idx,
    input  logic [OFF_W-1:0]            rd_off,
    output logic                        rd_valid,
    output logic [TAG_WD-1:0]           rd_tag,
    output logic [31:0]                 rd_word,
    input  logic                        we,
    input  logic [IDX_W-1:0]            wr_idx,
    input  logic [TAG_WD-1:0]           wr_tag,
    input  logic [LINE_WORDS-1:0][31:0] wr_line
);

    logic [SETS-1:0]             valid_q;
    logic [TAG_WD-1:0]           tag_q  [SETS];
    logic [LINE_WORDS-1:0][31:0] data_q [SETS];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (we) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    // Tag and data need no reset: valid gates every use.
    always_ff @(posedge clk) begin
        if (we) begin
            tag_q[wr_idx]  <= wr_tag;
            data_q[wr_idx] <= wr_line;
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_word  = data_q[rd_idx][rd_off];

endmodule

// File: rtl/ic_stage.sv
// Instruction-cache stage: 2-way set-associative lookup, refill FSM and IC-to-ID register.
module ic_stage
    import ic_stage_pkg::*;
#(
    parameter int unsigned SETS       = 128,
    parameter int unsigned LINE_WORDS = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  stall_bus_t             stall,
    input  logic                   flush,
    input  logic                   br_e,
    input  logic [IT_TO_IC_WD-1:0] it_to_ic_bus,
    input  logic                   inst_uncached,
    input  logic [TAG_WD-1:0]      inst_tag,
    output logic                   stallreq_ic,
    ic_stage_if.master             mem,
    output logic [IC_TO_ID_WD-1:0] ic_to_id_bus
);

    localparam int unsigned IDX_W   = $clog2(SETS);
    localparam int unsigned OFF_W   = $clog2(LINE_WORDS);
    localparam int unsigned IDX_LSB = OFF_W + 2;

    ic_state_e                   state_q, state_d;
    logic [31:0]                 rd_addr_q, rd_addr_d;
    logic                        rd_type_q, rd_type_d;
    logic [OFF_W-1:0]            off_q, off_d, cnt_q, cnt_d, cap_off;
    logic [LINE_WORDS-1:0][31:0] line_q, line_d, fill_line;
    logic [31:0]                 inst_q, inst_d;
    logic                        cancel_q, cancel_d;
    logic [SETS-1:0]             lru_q, lru_d;
    logic [IC_TO_ID_WD-1:0]      ic_next, ic_to_id_q;

    logic [31:0]       pc;
    logic              kill, req, hit, hit_way, victim;
    logic [IDX_W-1:0]  look_idx, fill_idx;
    logic [OFF_W-1:0]  off;
    logic [1:0]        way_valid, way_hit, way_we;
    logic [TAG_WD-1:0] way_tag  [2];
    logic [31:0]       way_word [2];
    logic              unused_stall;

    assign unused_stall = ^{stall[STALL_WD-1:4], stall[1:0]};

    assign pc       = it_to_ic_bus[IT_PC_MSB:0];
    assign kill     = flush | br_e;
    assign req      = it_to_ic_bus[IT_FE_BIT] & ~kill;
    assign off      = pc[2 +: OFF_W];
    assign fill_idx = rd_addr_q[IDX_LSB +: IDX_W];
    // Outside IDLE the read port follows the line being filled so victim choice sees its set.
    assign look_idx = (state_q == StIdle) ? pc[IDX_LSB +: IDX_W] : fill_idx;

    for (genvar w = 0; w < 2; w++) begin : g_way
        ic_way_array #(
            .SETS       (SETS),
            .LINE_WORDS (LINE_WORDS)
        ) u_way (
            .clk      (clk),
            .rst      (rst),
            .rd_idx   (look_idx),
            .rd_off   (off),
            .rd_valid (way_valid[w]),
            .rd_tag   (way_tag[w]),
            .rd_word  (way_word[w]),
            .we       (way_we[w]),
            .wr_idx   (fill_idx),
            .wr_tag   (rd_addr_q[31:12]),
            .wr_line  (fill_line)
        );
        assign way_hit[w] = way_valid[w] & (way_tag[w] == inst_tag);
    end

    assign hit     = req & ~inst_uncached & (|way_hit);
    assign hit_way = ~way_hit[0];
    assign victim  = ~way_valid[0] ? 1'b0 : (~way_valid[1] ? 1'b1 : ~lru_q[fill_idx]);
    // An uncached fetch returns a single beat, so its word always arrives first.
    assign cap_off = (rd_type_q == RD_TYPE_LINE) ? off_q : '0;

    always_comb begin
        state_d     = state_q;
        rd_addr_d   = rd_addr_q;
        rd_type_d   = rd_type_q;
        off_d       = off_q;
        cnt_d       = cnt_q;
        line_d      = line_q;
        inst_d      = inst_q;
        cancel_d    = cancel_q;
        lru_d       = lru_q;
        way_we      = '0;
        stallreq_ic = 1'b0;
        ic_next     = '0;
        fill_line         = line_q;
        fill_line[cnt_q]  = mem.ret_data;

        unique case (state_q)
            StIdle: begin
                cancel_d = 1'b0;
                if (req && (inst_uncached || !hit)) begin
                    stallreq_ic = 1'b1;
                    state_d     = StMiss;
                    cnt_d       = '0;
                    off_d       = off;
                    if (inst_uncached) begin
                        rd_type_d = RD_TYPE_WORD;
                        rd_addr_d = {inst_tag, pc[11:0]};
                    end else begin
                        rd_type_d = RD_TYPE_LINE;
                        rd_addr_d = {inst_tag, pc[11:IDX_LSB], {IDX_LSB{1'b0}}};
                    end
                end else begin
                    ic_next = {it_to_ic_bus[IT_TO_IC_WD-1:IT_FE_BIT], hit ? way_word[hit_way] : 32'h0, pc};
                    if (hit) begin
                        lru_d[look_idx] = hit_way;
                    end
                end
            end
            StMiss: begin
                stallreq_ic = 1'b1;
                if (kill) cancel_d = 1'b1;
                if (mem.rd_rdy) state_d = StRefill;
            end
            StRefill: begin
                stallreq_ic = 1'b1;
                if (kill) cancel_d = 1'b1;
                if (mem.ret_valid) begin
                    line_d = fill_line;
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == cap_off) inst_d = mem.ret_data;
                    if (mem.ret_last) begin
                        state_d = StDone;
                        if (rd_type_q == RD_TYPE_LINE) begin
                            way_we[victim]  = 1'b1;
                            lru_d[fill_idx] = victim;
                        end
                    end
                end
            end
            StDone: begin
                if (!cancel_q) begin
                    ic_next = {it_to_ic_bus[IT_TO_IC_WD-1:IT_FE_BIT], inst_q, pc};
                end
                if (kill) cancel_d = 1'b1;
                // Hold the captured word until this stage may advance.
                if (stall[2] == NO_STOP) begin
                    state_d  = StIdle;
                    cancel_d = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            rd_addr_q <= '0;
            rd_type_q <= RD_TYPE_WORD;
            off_q     <= '0;
            cnt_q     <= '0;
            line_q    <= '0;
            inst_q    <= '0;
            cancel_q  <= 1'b0;
            lru_q     <= '0;
        end else begin
            state_q   <= state_d;
            rd_addr_q <= rd_addr_d;
            rd_type_q <= rd_type_d;
            off_q     <= off_d;
            cnt_q     <= cnt_d;
            line_q    <= line_d;
            inst_q    <= inst_d;
            cancel_q  <= cancel_d;
            lru_q     <= lru_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || kill) begin
            ic_to_id_q <= '0;
        end else if (stall[2] == STOP && stall[3] == NO_STOP) begin
            ic_to_id_q <= '0;
        end else if (stall[2] == NO_STOP) begin
            ic_to_id_q <= ic_next;
        end
    end

    assign ic_to_id_bus = ic_to_id_q;
    assign mem.rd_req   = (state_q == StMiss);
    assign mem.rd_type  = rd_type_q;
    assign mem.rd_addr  = rd_addr_q;

endmodule

// File: tb/tb_ic_stage.sv
// Directed bench for ic_stage: table of fetches plus hand sequences for stall, exception, reset.
module tb_ic_stage;
    import ic_stage_pkg::*;

    logic                   clk = 1'b0;
    logic                   rst;
    stall_bus_t             stall;
    logic                   flush;
    logic                   br_e;
    logic [IT_TO_IC_WD-1:0] it_to_ic_bus;
    logic                   inst_uncached;
    logic [TAG_WD-1:0]      inst_tag;
    logic                   stallreq_ic;
    logic [IC_TO_ID_WD-1:0] ic_to_id_bus;

    ic_stage_if mem ();

    ic_stage #(
        .SETS       (128),
        .LINE_WORDS (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .flush         (flush),
        .br_e          (br_e),
        .it_to_ic_bus  (it_to_ic_bus),
        .inst_uncached (inst_uncached),
        .inst_tag      (inst_tag),
        .stallreq_ic   (stallreq_ic),
        .mem           (mem),
        .ic_to_id_bus  (ic_to_id_bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [19:0] tag;
        logic        unc;
        logic        hit;
        logic [31:0] base;
        int          nbeats;
        int          br_beat;
        logic [31:0] exp_inst;
        logic        exp_type;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t vecs[15];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        it_to_ic_bus  = '0;
        inst_uncached = 1'b0;
        inst_tag      = '0;
    endtask

    task automatic drive_fetch(input logic [31:0] pc, input logic [19:0] tag, input logic unc);
        it_to_ic_bus            = '0;
        it_to_ic_bus[31:0]      = pc;
        it_to_ic_bus[IT_FE_BIT] = 1'b1;
        inst_tag                = tag;
        inst_uncached           = unc;
    endtask

    task automatic hit_fetch(input int i, input vec_t v);
        drive_fetch(v.pc, v.tag, 1'b0);
        #3;
        check($sformatf("v%0d_hit_nostall", i), 128'(stallreq_ic), 128'(1'b0));
        check($sformatf("v%0d_hit_noreq", i), 128'(mem.rd_req), 128'(1'b0));
        step();
        check($sformatf("v%0d_hit_out", i), 128'(ic_to_id_bus), 128'({33'h1, v.exp_inst, v.pc}));
        idle_bus();
    endtask

    task automatic miss_fetch(input int i, input vec_t v);
        int n;
        drive_fetch(v.pc, v.tag, v.unc);
        #3;
        check($sformatf("v%0d_stall_detect", i), 128'(stallreq_ic), 128'(1'b1));
        step();
        n = 0;
        while (mem.rd_req !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check($sformatf("v%0d_rd_req", i), 128'(mem.rd_req), 128'(1'b1));
        check($sformatf("v%0d_rd_type", i), 128'(mem.rd_type), 128'(v.exp_type));
        check($sformatf("v%0d_rd_addr", i), 128'(mem.rd_addr), 128'(v.exp_addr));
        // A stray beat while still in MISS must be ignored.
        mem.rd_rdy    = 1'b1;
        mem.ret_valid = 1'b1;
        mem.ret_data  = 32'hdead_beef;
        step();
        mem.rd_rdy = 1'b0;
        for (int k = 0; k < v.nbeats; k++) begin
            mem.ret_valid = 1'b1;
            mem.ret_data  = v.base + 32'(k);
            mem.ret_last  = (k == v.nbeats - 1);
            br_e          = (k == v.br_beat);
            step();
        end
        mem.ret_valid = 1'b0;
        mem.ret_last  = 1'b0;
        br_e          = 1'b0;
        #3;
        check($sformatf("v%0d_stall_done", i), 128'(stallreq_ic), 128'(1'b0));
        step();
        if (v.br_beat >= 0) begin
            check($sformatf("v%0d_cancel_out", i), 128'(ic_to_id_bus), 128'(0));
        end else begin
            check($sformatf("v%0d_miss_out", i), 128'(ic_to_id_bus),
                  128'({33'h1, v.exp_inst, v.pc}));
        end
        idle_bus();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1);
    end

    initial begin
        logic [IT_TO_IC_WD-1:0] exc;

        rst           = 1'b1;
        stall         = '0;
        flush         = 1'b0;
        br_e          = 1'b0;
        mem.rd_rdy    = 1'b0;
        mem.ret_valid = 1'b0;
        mem.ret_last  = 1'b0;
        mem.ret_data  = '0;
        idle_bus();
        step();
        step();
        check("reset_stallreq", 128'(stallreq_ic), 128'(1'b0));
        check("reset_rd_req", 128'(mem.rd_req), 128'(1'b0));
        check("reset_out", 128'(ic_to_id_bus), 128'(0));
        rst = 1'b0;

        //           pc            tag       unc  hit  base          nb br  inst          type addr
        vecs[0]  = '{32'h1000_0040, 20'h10000, 1'b0, 1'b0, 32'hA0, 8, -1, 32'hA0, 1'b1, 32'h1000_0040};
        vecs[1]  = '{32'h1000_0044, 20'h10000, 1'b0, 1'b1, 32'h0, 0, -1, 32'hA1, 1'b1, 32'h0};
        vecs[2]  = '{32'h1FC0_0000, 20'h1FC00, 1'b1, 1'b0, 32'h3C08_BFC0, 1, -1, 32'h3C08_BFC0,
                     1'b0, 32'h1FC0_0000};
        vecs[3]  = '{32'h1FC0_0000, 20'h1FC00, 1'b1, 1'b0, 32'h3C08_BFC0, 1, -1, 32'h3C08_BFC0,
                     1'b0, 32'h1FC0_0000};
        vecs[4]  = '{32'h2000_0048, 20'h20000, 1'b0, 1'b0, 32'hB0, 8, -1, 32'hB2, 1'b1, 32'h2000_0040};
        vecs[5]  = '{32'h1000_0040, 20'h10000, 1'b0, 1'b1, 32'h0, 0, -1, 32'hA0, 1'b1, 32'h0};
        vecs[6]  = '{32'h3000_0040, 20'h30000, 1'b0, 1'b0, 32'hC0, 8, -1, 32'hC0, 1'b1, 32'h3000_0040};
        vecs[7]  = '{32'h1000_0044, 20'h10000, 1'b0, 1'b1, 32'h0, 0, -1, 32'hA1, 1'b1, 32'h0};
        vecs[8]  = '{32'h3000_0044, 20'h30000, 1'b0, 1'b1, 32'h0, 0, -1, 32'hC1, 1'b1, 32'h0};
        vecs[9]  = '{32'h2000_0048, 20'h20000, 1'b0, 1'b0, 32'hD0, 8, -1, 32'hD2, 1'b1, 32'h2000_0040};
        vecs[10] = '{32'h2000_004C, 20'h20000, 1'b0, 1'b1, 32'h0, 0, -1, 32'hD3, 1'b1, 32'h0};
        vecs[11] = '{32'h3000_0048, 20'h30000, 1'b0, 1'b1, 32'h0, 0, -1, 32'hC2, 1'b1, 32'h0};
        vecs[12] = '{32'h1000_0040, 20'h10000, 1'b0, 1'b0, 32'hF0, 8, -1, 32'hF0, 1'b1, 32'h1000_0040};
        vecs[13] = '{32'h4000_0080, 20'h40000, 1'b0, 1'b0, 32'hE0, 8, 3, 32'h0, 1'b1, 32'h4000_0080};
        vecs[14] = '{32'h4000_0084, 20'h40000, 1'b0, 1'b1, 32'h0, 0, -1, 32'hE1, 1'b1, 32'h0};

        for (int i = 0; i < 15; i++) begin
            if (vecs[i].hit) hit_fetch(i, vecs[i]);
            else             miss_fetch(i, vecs[i]);
        end

        // Bubble while stall[2] stops, then deliver, then hold with both stopped.
        drive_fetch(32'h4000_0088, 20'h40000, 1'b0);
        stall[2] = STOP;
        stall[3] = NO_STOP;
        #3;
        check("bubble_nostall", 128'(stallreq_ic), 128'(1'b0));
        step();
        check("bubble_out", 128'(ic_to_id_bus), 128'(0));
        stall[2] = NO_STOP;
        step();
        check("release_out", 128'(ic_to_id_bus), 128'({33'h1, 32'hE2, 32'h4000_0088}));
        stall[2] = STOP;
        stall[3] = STOP;
        idle_bus();
        step();
        check("hold_out", 128'(ic_to_id_bus), 128'({33'h1, 32'hE2, 32'h4000_0088}));
        stall = '0;

        // TLB-refill exception with fetch disabled: passthrough only.
        exc                    = '0;
        exc[31:0]              = 32'h5000_0000;
        exc[IT_TLB_REFILL_BIT] = 1'b1;
        exc[64:36]             = 29'h0ABC_DEF;
        it_to_ic_bus           = exc;
        inst_tag               = 20'h50000;
        #3;
        check("exc_nostall", 128'(stallreq_ic), 128'(1'b0));
        check("exc_noreq", 128'(mem.rd_req), 128'(1'b0));
        step();
        check("exc_out", 128'(ic_to_id_bus), 128'({exc[64:32], 32'h0, exc[31:0]}));
        check("exc_noreq_after", 128'(mem.rd_req), 128'(1'b0));
        idle_bus();

        // Reset in the middle of a refill clears every valid bit.
        drive_fetch(32'h3000_0044, 20'h30000, 1'b0);
        #3;
        check("pre_rst_hit", 128'(stallreq_ic), 128'(1'b0));
        step();
        drive_fetch(32'h6000_0000, 20'h60000, 1'b0);
        step();
        mem.rd_rdy = 1'b1;
        step();
        mem.rd_rdy    = 1'b0;
        mem.ret_valid = 1'b1;
        mem.ret_data  = 32'h1234_5678;
        step();
        step();
        rst = 1'b1;
        step();
        rst           = 1'b0;
        mem.ret_valid = 1'b0;
        check("rst_mid_rd_req", 128'(mem.rd_req), 128'(1'b0));
        check("rst_mid_out", 128'(ic_to_id_bus), 128'(0));
        drive_fetch(32'h3000_0044, 20'h30000, 1'b0);
        #3;
        check("rst_cleared_miss", 128'(stallreq_ic), 128'(1'b1));
        step();
        check("rst_refetch_req", 128'(mem.rd_req), 128'(1'b1));
        check("rst_refetch_addr", 128'(mem.rd_addr), 128'(32'h3000_0040));
        rst = 1'b1;
        idle_bus();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
